// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP transmit credit gate: credit classes,
// transmit FSM states, TLP header field positions and header decode helpers.
// No ports; imported by tlp_fc_credit_bank and tlp_tx_credit_gate.
package tlp_pkg;

  // Flow-control credit classes. The encoding matches fc_upd_type on the port,
  // so an update's type can index the credit bank directly; 2'b11 selects nothing.
  localparam logic [1:0] CLS_P   = 2'b00;
  localparam logic [1:0] CLS_NP  = 2'b01;
  localparam logic [1:0] CLS_CPL = 2'b10;
  localparam int         NUM_CLS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
    ST_DATA = 2'b10
  } tx_state_e;

  // Header DW0 field positions.
  localparam int FMT_HI  = 31;
  localparam int FMT_LO  = 29;
  localparam int TYPE_HI = 28;
  localparam int TYPE_LO = 24;
  localparam int LEN_HI  = 9;
  localparam int LEN_LO  = 0;

  localparam logic [4:0] TYPE_MWR = 5'b00000;
  localparam logic [4:0] TYPE_CPL = 5'b01010;

  // One beat of payload holds at most 4 DW.
  localparam int MAX_LEN_DW = 4;

  // fmt[1] marks a TLP that carries a data payload.
  function automatic logic hdr_has_data(input logic [2:0] fmt);
    return fmt[1];
  endfunction

  function automatic logic [1:0] hdr_class(input logic has_data, input logic [4:0] typ);
    if (typ == TYPE_CPL)                 return CLS_CPL;
    else if (has_data && typ == TYPE_MWR) return CLS_P;
    else                                 return CLS_NP;
  endfunction

endpackage

// File: rtl/tlp_fc_credit_bank.sv
// Per-class flow-control credit bank: cumulative limits and consumed counters
// for P, NP and CPL, header and data, with modular (wrapping) arithmetic.
// Ports: clk/rst; upd_* overwrites one class's limits; cons_* consumes credits
// for one TLP; chk_* selects the class/need to evaluate; hdr_ok_o/data_ok_o.
// Latency: updates and consumes take effect at the next clock edge.
module tlp_fc_credit_bank
  import tlp_pkg::*;
#(
  parameter int HDR_CW          = 8,
  parameter int DATA_CW         = 12,
  parameter int INIT_HDR_LIMIT  = 0,
  parameter int INIT_DATA_LIMIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_vld_i,
  input  logic [1:0]         upd_cls_i,
  input  logic [HDR_CW-1:0]  upd_hdr_i,
  input  logic [DATA_CW-1:0] upd_data_i,
  input  logic               cons_vld_i,
  input  logic [1:0]         cons_cls_i,
  input  logic               cons_data_i,
  input  logic [1:0]         chk_cls_i,
  input  logic               chk_data_i,
  output logic               hdr_ok_o,
  output logic               data_ok_o
);

  logic [HDR_CW-1:0]  hdr_lim_q  [NUM_CLS];
  logic [HDR_CW-1:0]  hdr_cons_q [NUM_CLS];
  logic [DATA_CW-1:0] data_lim_q [NUM_CLS];
  logic [DATA_CW-1:0] data_cons_q[NUM_CLS];

  logic [HDR_CW-1:0]  hdr_avail;
  logic [DATA_CW-1:0] data_avail;

  // Limits and consumed counts are both free-running modulo 2^width, so the
  // difference is the number of credits still available even across wraps.
  assign hdr_avail  = hdr_lim_q[chk_cls_i]  - hdr_cons_q[chk_cls_i];
  assign data_avail = data_lim_q[chk_cls_i] - data_cons_q[chk_cls_i];
  assign hdr_ok_o   = (hdr_avail != '0);
  assign data_ok_o  = !chk_data_i || (data_avail != '0);

  // Limit overwrite and consume touch different registers, so a same-cycle
  // update and pop on one class are both applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLS; c++) begin
        hdr_lim_q[c]   <= HDR_CW'(INIT_HDR_LIMIT);
        data_lim_q[c]  <= DATA_CW'(INIT_DATA_LIMIT);
        hdr_cons_q[c]  <= '0;
        data_cons_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CLS; c++) begin
        if (upd_vld_i && upd_cls_i == 2'(c)) begin
          hdr_lim_q[c]  <= upd_hdr_i;
          data_lim_q[c] <= upd_data_i;
        end
        if (cons_vld_i && cons_cls_i == 2'(c)) begin
          hdr_cons_q[c] <= hdr_cons_q[c] + HDR_CW'(1);
          if (cons_data_i) begin
            data_cons_q[c] <= data_cons_q[c] + DATA_CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/tlp_tx_credit_gate.sv
// Credit gate between the TLP FIFO and the transmit link: pops a single-beat TLP
// only when its class has header (and data) credits, then sends header + optional data beat.
// Latency: header beat the cycle after the pop; at least one idle cycle between TLPs.
// Backpressure: in_ready low while busy or credit-starved (head-of-line blocks); tx_* hold while !tx_ready.
// Ports: clk/rst; in_* from the FIFO (in_ready is the pop strobe); tx_* link stream;
// fc_upd_* credit-limit updates; credit_blocked status; err_malformed drop pulse.
module tlp_tx_credit_gate
  import tlp_pkg::*;
#(
  parameter int TLP_DATA_WIDTH  = 128,
  parameter int TLP_HDR_WIDTH   = 128,
  parameter int HDR_CW          = 8,
  parameter int DATA_CW         = 12,
  parameter int INIT_HDR_LIMIT  = 0,
  parameter int INIT_DATA_LIMIT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TLP_DATA_WIDTH-1:0] in_data,
  input  logic [TLP_HDR_WIDTH-1:0]  in_hdr,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [TLP_HDR_WIDTH-1:0]  tx_data,
  output logic                      tx_valid,
  output logic                      tx_sop,
  output logic                      tx_eop,
  input  logic                      tx_ready,
  input  logic                      fc_upd_valid,
  input  logic [1:0]                fc_upd_type,
  input  logic [HDR_CW-1:0]         fc_upd_hdr,
  input  logic [DATA_CW-1:0]        fc_upd_data,
  output logic                      credit_blocked,
  output logic                      err_malformed
);

  tx_state_e                 state_q;
  logic [TLP_DATA_WIDTH-1:0] data_q;
  logic                      has_data_q;
  logic [TLP_HDR_WIDTH-1:0]  tx_data_q;
  logic                      tx_valid_q;
  logic                      tx_sop_q;
  logic                      tx_eop_q;
  logic                      err_q;

  // Head-of-FIFO decode.
  logic       has_data;
  logic [9:0] len;
  logic [1:0] cls;
  logic       malformed;
  logic       hdr_ok;
  logic       data_ok;
  logic       credit_ok;
  logic       idle;
  logic       pop_good;
  logic       pop_bad;

  assign has_data  = hdr_has_data(in_hdr[FMT_HI:FMT_LO]);
  assign len       = in_hdr[LEN_HI:LEN_LO];
  assign cls       = hdr_class(has_data, in_hdr[TYPE_HI:TYPE_LO]);
  assign malformed = has_data && (len == '0 || len > 10'(MAX_LEN_DW));
  assign credit_ok = hdr_ok && data_ok;

  // rst is folded in so the combinational outputs read 0 while reset is held,
  // even if the FIFO presents a malformed entry that would otherwise be popped.
  assign idle           = !rst && (state_q == ST_IDLE);
  assign in_ready       = idle && in_valid && (malformed || credit_ok);
  assign credit_blocked = idle && in_valid && !malformed && !credit_ok;
  assign pop_good       = in_ready && !malformed;
  assign pop_bad        = in_ready && malformed;

  tlp_fc_credit_bank #(
    .HDR_CW         (HDR_CW),
    .DATA_CW        (DATA_CW),
    .INIT_HDR_LIMIT (INIT_HDR_LIMIT),
    .INIT_DATA_LIMIT(INIT_DATA_LIMIT)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .upd_vld_i  (fc_upd_valid),
    .upd_cls_i  (fc_upd_type),
    .upd_hdr_i  (fc_upd_hdr),
    .upd_data_i (fc_upd_data),
    .cons_vld_i (pop_good),
    .cons_cls_i (cls),
    .cons_data_i(has_data),
    .chk_cls_i  (cls),
    .chk_data_i (has_data),
    .hdr_ok_o   (hdr_ok),
    .data_ok_o  (data_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      has_data_q <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= pop_bad;
      unique case (state_q)
        ST_IDLE: begin
          if (pop_good) begin
            data_q     <= in_data;
            has_data_q <= has_data;
            tx_data_q  <= in_hdr;
            tx_valid_q <= 1'b1;
            tx_sop_q   <= 1'b1;
            tx_eop_q   <= !has_data;
            state_q    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            if (has_data_q) begin
              tx_data_q <= data_q;
              tx_sop_q  <= 1'b0;
              tx_eop_q  <= 1'b1;
              state_q   <= ST_DATA;
            end else begin
              tx_data_q  <= '0;
              tx_valid_q <= 1'b0;
              tx_sop_q   <= 1'b0;
              tx_eop_q   <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tx_ready) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_eop_q   <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign tx_sop        = tx_sop_q;
  assign tx_eop        = tx_eop_q;
  assign err_malformed = err_q;

endmodule

// File: tb/tb_tlp_tx_credit_gate.sv
// Self-checking bench for tlp_tx_credit_gate: directed scenarios plus random
// traffic, every cycle compared against a queue-based credit/beat reference model.
module tb_tlp_tx_credit_gate;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data, in_hdr, tx_data;
  logic         in_valid, in_ready, tx_valid, tx_sop, tx_eop, tx_ready;
  logic         fc_upd_valid;
  logic [1:0]   fc_upd_type;
  logic [7:0]   fc_upd_hdr;
  logic [11:0]  fc_upd_data;
  logic         credit_blocked, err_malformed;

  always #5 clk = ~clk;

  tlp_tx_credit_gate dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready),
    .fc_upd_valid(fc_upd_valid), .fc_upd_type(fc_upd_type),
    .fc_upd_hdr(fc_upd_hdr), .fc_upd_data(fc_upd_data),
    .credit_blocked(credit_blocked), .err_malformed(err_malformed)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [127:0] d;
    bit           sop;
    bit           eop;
  } beat_t;

  int    lim_h[3], lim_d[3], con_h[3], con_d[3];
  beat_t beats[$];
  bit    err_exp;
  bit    last_pop;

  function automatic int cls_of(input logic [127:0] h);
    if (h[28:24] == 5'b01010) return 2;
    if (h[30] && h[28:24] == 5'b00000) return 0;
    return 1;
  endfunction

  function automatic bit malformed_of(input logic [127:0] h);
    return h[30] && (h[9:0] == 0 || h[9:0] > 4);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      lim_h[c] = 0; lim_d[c] = 0; con_h[c] = 0; con_d[c] = 0;
    end
    beats.delete();
    err_exp  = 0;
    last_pop = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx_valid"}, tx_valid, 0);
    check_eq({tag, "_tx_sop"}, tx_sop, 0);
    check_eq({tag, "_tx_eop"}, tx_eop, 0);
    check_eq({tag, "_tx_data"}, tx_data, 0);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_credit_blocked"}, credit_blocked, 0);
    check_eq({tag, "_err_malformed"}, err_malformed, 0);
  endtask

  // One clock cycle: compare at the falling edge, advance the model to what
  // the next rising edge will do, then return 1 time unit after that edge.
  task automatic tick();
    bit busy, has, mal, ok, exp_rdy, exp_blk;
    int c, ha, da;
    beat_t b;
    @(negedge clk);
    if (rst) begin
      check_reset_outputs("rst_hold");
      model_reset();
    end else begin
      busy = (beats.size() != 0);
      has  = in_hdr[30];
      mal  = malformed_of(in_hdr);
      c    = cls_of(in_hdr);
      ha   = (lim_h[c] - con_h[c]) & 255;
      da   = (lim_d[c] - con_d[c]) & 4095;
      ok   = (ha != 0) && (!has || da != 0);
      exp_rdy = !busy && in_valid && (mal || ok);
      exp_blk = !busy && in_valid && !mal && !ok;
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("credit_blocked", credit_blocked, exp_blk);
      check_eq("err_malformed", err_malformed, err_exp);
      check_eq("tx_valid", tx_valid, busy);
      if (busy) begin
        check_eq("tx_sop", tx_sop, beats[0].sop);
        check_eq("tx_eop", tx_eop, beats[0].eop);
        check_eq("tx_data", tx_data, beats[0].d);
        if (tx_ready) beats.delete(0);
      end
      err_exp = exp_rdy && mal;
      if (exp_rdy && !mal) begin
        b.d = in_hdr; b.sop = 1; b.eop = !has;
        beats.push_back(b);
        if (has) begin
          b.d = in_data; b.sop = 0; b.eop = 1;
          beats.push_back(b);
          con_d[c] = (con_d[c] + 1) & 4095;
        end
        con_h[c] = (con_h[c] + 1) & 255;
      end
      if (fc_upd_valid && fc_upd_type != 2'b11) begin
        lim_h[fc_upd_type] = fc_upd_hdr;
        lim_d[fc_upd_type] = fc_upd_data;
      end
      last_pop = exp_rdy;
    end
    @(posedge clk);
    #1;
    fc_upd_valid = 1'b0;
    if (last_pop) in_valid = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic present(input logic [2:0] fmt, input logic [4:0] typ, input logic [9:0] len);
    logic [127:0] h;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[31:29] = fmt;
    h[28:24] = typ;
    h[9:0]   = len;
    in_hdr   = h;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
  endtask

  task automatic fc(input int t, input int h, input int d);
    fc_upd_valid = 1'b1;
    fc_upd_type  = 2'(t);
    fc_upd_hdr   = 8'(h);
    fc_upd_data  = 12'(d);
  endtask

  task automatic wait_pop(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      got = last_pop;
    end
    check_eq("pop_seen", got, 1);
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (beats.size() == 0) && !err_exp;
    end
    check_eq("drain_done", done, 1);
  endtask

  task automatic present_random();
    logic [2:0] f;
    f = 3'b010;
    f[0] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: present(f, 5'b00000, 10'($urandom_range(1, 4)));            // MWr
      1: present({2'b00, f[0]}, 5'b00000, 10'($urandom));             // MRd
      2: present(3'b000, 5'b01010, 10'($urandom));                     // Cpl
      3: present(3'b010, 5'b01010, 10'($urandom_range(1, 4)));        // CplD
      4: present(3'b010, 5'b00010, 10'd1);                             // IOWr (NP + data)
      default: present(f, 5'b00000, ($urandom_range(0, 1) != 0) ? 10'd0 : 10'($urandom_range(5, 1023)));
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_hdr = '0; in_data = '0; tx_ready = 1'b1;
    fc_upd_valid = 0; fc_upd_type = 0; fc_upd_hdr = 0; fc_upd_data = 0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();

    // MWr blocked at zero limits, then released by a P update.
    present(3'b010, 5'b00000, 10'd2);
    repeat (3) tick();
    fc(0, 1, 1);
    tick();
    wait_pop(4);
    drain(8);

    // Two NP reads on limit 2, third blocks until limit 3.
    fc(1, 2, 0);
    tick();
    present(3'b000, 5'b00000, 10'd1); wait_pop(6);
    present(3'b000, 5'b00000, 10'd1); wait_pop(6);
    present(3'b000, 5'b00000, 10'd1);
    repeat (6) tick();
    fc(1, 3, 0);
    wait_pop(4);
    drain(8);

    // Malformed MWr (len 5, len 0) are dropped with error pulses.
    present(3'b010, 5'b00000, 10'd5); wait_pop(4);
    present(3'b011, 5'b00000, 10'd0); wait_pop(4);
    drain(6);

    // Link stall during the header beat.
    fc(0, 2, 2);
    tick();
    tx_ready = 1'b0;
    present(3'b010, 5'b00000, 10'd3);
    wait_pop(4);
    repeat (5) tick();
    tx_ready = 1'b1;
    drain(8);

    // Drive P header consumed to 255, then wrap with limit 0.
    fc(0, 255, 255);
    tick();
    for (int i = 0; i < 253; i++) begin
      present(3'b010, 5'b00000, 10'd1);
      wait_pop(6);
    end
    drain(8);
    fc(0, 0, 0);
    tick();
    present(3'b010, 5'b00000, 10'd4);
    wait_pop(4);
    drain(8);
    present(3'b010, 5'b00000, 10'd1);
    repeat (4) tick();
    fc(0, 1, 300);
    wait_pop(4);
    drain(8);

    // Asynchronous reset during the data beat.
    fc(0, 2, 300);
    tick();
    present(3'b010, 5'b00000, 10'd4);
    wait_pop(4);
    tick();
    tx_ready = 1'b0;
    tick();
    present(3'b000, 5'b00000, 10'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (3) tick();
    fc(1, 1, 0);
    tick();
    wait_pop(4);
    drain(8);

    // Random traffic with random credit returns and link backpressure.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 7) == 0) begin
        int t;
        t = $urandom_range(0, 3);
        if (t < 3) fc(t, con_h[t] + $urandom_range(0, 3), con_d[t] + $urandom_range(0, 3));
        else       fc(t, $urandom, $urandom);
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 1) != 0) present_random();
      tick();
    end
    tx_ready = 1'b1;
    in_valid = 1'b0;
    drain(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
